usb_fs_tx_engine: RTL

USB_FS_TX_ENGINE -- requirements
Module: usb_fs_tx_engine

---
 rtl/usb_fs_tx_engine.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_fs_tx_engine.sv
// USB full-speed transmit engine: SYNC, PID, optional DATA + CRC16, EOP, with NRZI and bit stuffing.
// Defining USB_FS_TX_BUSY_EN adds the tx_busy output.
module usb_fs_tx_engine (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tx_pkt_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_data_avail,
    input  logic [7:0] tx_data,
    output logic       tx_data_get,
    output logic       tx_pkt_end,
`ifdef USB_FS_TX_BUSY_EN
    output logic       tx_busy,
`endif
    output logic       usb_p_tx,
    output logic       usb_n_tx,
    output logic       usb_tx_en
);

    typedef enum logic [2:0] {
        StIdle, StSync, StPid, StData, StCrcLo, StCrcHi, StEopSe0, StEopJ
    } state_e;

    state_e      st_q, st_d;
    logic [1:0]  div_q, div_d;
    logic [7:0]  byte_q, byte_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  ones_q, ones_d;
    logic [15:0] crc_q, crc_d;
    logic [3:0]  pid_q, pid_d;
    logic        line_q, line_d;
    logic        se0_q, se0_d;
    logic        en_q, en_d;
    logic        get_q, get_d;
    logic        end_q, end_d;

    logic tick, stuff, byte_end, in_byte, data_pid, adv;
    logic emit, nbit, crc_en, load, eop;
    logic [7:0] nxt;

    // State describes the bit currently on the line; ticks pick the following bit.
    assign tick     = (st_q != StIdle) && (div_q == 2'd3);
    assign stuff    = (ones_q == 3'd6);
    assign byte_end = (idx_q == 3'd7);
    assign in_byte  = (st_q == StSync) || (st_q == StPid) || (st_q == StData) ||
                      (st_q == StCrcLo) || (st_q == StCrcHi);
    assign data_pid = (pid_q[1:0] == 2'b11);
    assign adv      = tick && !stuff && byte_end;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q <= StIdle;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle:   if (tx_pkt_start) st_d = StSync;
            StSync:   if (adv) st_d = StPid;
            StPid:    if (adv) st_d = !data_pid ? StEopSe0 : (tx_data_avail ? StData : StCrcLo);
            StData:   if (adv) st_d = tx_data_avail ? StData : StCrcLo;
            StCrcLo:  if (adv) st_d = StCrcHi;
            StCrcHi:  if (adv) st_d = StEopSe0;
            StEopSe0: if (tick && idx_q[0]) st_d = StEopJ;
            StEopJ:   if (tick) st_d = StIdle;
        endcase
    end

    always_comb begin
        div_d  = (st_q == StIdle) ? 2'd0 : div_q + 2'd1;
        byte_d = byte_q;
        idx_d  = idx_q;
        ones_d = ones_q;
        crc_d  = crc_q;
        pid_d  = pid_q;
        line_d = line_q;
        se0_d  = se0_q;
        en_d   = en_q;
        get_d  = 1'b0;
        end_d  = 1'b0;
        emit   = 1'b0;
        nbit   = 1'b0;
        crc_en = 1'b0;
        load   = 1'b0;
        eop    = 1'b0;
        nxt    = 8'h00;
        if (st_q == StIdle) begin
            if (tx_pkt_start) begin
                en_d  = 1'b1;
                pid_d = tx_pid;
                crc_d = 16'hFFFF;
                load  = 1'b1;
                nxt   = 8'h80;
            end
        end else if (tick) begin
            if (stuff) begin
                emit = 1'b1;
            end else if (in_byte && !byte_end) begin
                byte_d = {1'b0, byte_q[7:1]};
                idx_d  = idx_q + 3'd1;
                nbit   = byte_q[1];
                emit   = 1'b1;
                crc_en = (st_q == StData);
            end else begin
                unique case (st_q)
                    StIdle: ;
                    StSync: begin
                        load = 1'b1;
                        nxt  = {~pid_q, pid_q};
                    end
                    StPid, StData: begin
                        if (st_q == StPid && !data_pid) begin
                            eop = 1'b1;
                        end else if (tx_data_avail) begin
                            load   = 1'b1;
                            nxt    = tx_data;
                            get_d  = 1'b1;
                            crc_en = 1'b1;
                        end else begin
                            load = 1'b1;
                            nxt  = ~crc_q[7:0];
                        end
                    end
                    StCrcLo: begin
                        load = 1'b1;
                        nxt  = ~crc_q[15:8];
                    end
                    StCrcHi: eop = 1'b1;
                    StEopSe0: begin
                        if (!idx_q[0]) begin
                            idx_d = 3'd1;
                        end else begin
                            se0_d  = 1'b0;
                            line_d = 1'b1;
                        end
                    end
                    StEopJ: begin
                        en_d   = 1'b0;
                        end_d  = 1'b1;
                        line_d = 1'b1;
                    end
                endcase
            end
        end
        if (load) begin
            byte_d = nxt;
            idx_d  = 3'd0;
            nbit   = nxt[0];
            emit   = 1'b1;
        end
        if (eop) begin
            se0_d  = 1'b1;
            idx_d  = 3'd0;
            ones_d = 3'd0;
        end
        // NRZI: a 0 toggles the line, a 1 holds it and extends the run of ones.
        if (emit) begin
            line_d = nbit ? line_q : ~line_q;
            ones_d = nbit ? ones_q + 3'd1 : 3'd0;
        end
        if (crc_en) begin
            crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ nbit) ? 16'hA001 : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q  <= 2'd0;
            byte_q <= 8'h00;
            idx_q  <= 3'd0;
            ones_q <= 3'd0;
            crc_q  <= 16'hFFFF;
            pid_q  <= 4'h0;
            line_q <= 1'b1;
            se0_q  <= 1'b0;
            en_q   <= 1'b0;
            get_q  <= 1'b0;
            end_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            byte_q <= byte_d;
            idx_q  <= idx_d;
            ones_q <= ones_d;
            crc_q  <= crc_d;
            pid_q  <= pid_d;
            line_q <= line_d;
            se0_q  <= se0_d;
            en_q   <= en_d;
            get_q  <= get_d;
            end_q  <= end_d;
        end
    end

    assign usb_p_tx    = line_q & ~se0_q;
    assign usb_n_tx    = ~line_q & ~se0_q;
    assign usb_tx_en   = en_q;
    assign tx_data_get = get_q;
    assign tx_pkt_end  = end_q;
`ifdef USB_FS_TX_BUSY_EN
    assign tx_busy     = en_q | end_q;
`endif

endmodule
